// File: rtl/uart_mon_pkg.sv
// Shared types, constants and helpers for the UART frame monitor.
// Optional feature macro: UART_MON_COUNTERS_EN (see uart_mon_channel).
package uart_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } mon_state_e;

  localparam logic [2:0] PAR_NONE   = 3'd0;
  localparam logic [2:0] PAR_ODD    = 3'd1;
  localparam logic [2:0] PAR_EVEN   = 3'd2;
  localparam logic [2:0] PAR_STICK0 = 3'd3;
  localparam logic [2:0] PAR_STICK1 = 3'd4;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0] TICK_LAST    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMPLE_EARLY = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LATE  = 4'd9;

  // Out-of-range data lengths fall back to the common 8-bit format.
  function automatic logic [3:0] eff_data_bits(input logic [3:0] cfg);
    if ((cfg >= 4'd5) && (cfg <= 4'd9)) begin
      eff_data_bits = cfg;
    end else begin
      eff_data_bits = 4'd8;
    end
  endfunction

  function automatic logic parity_enabled(input logic [2:0] mode);
    case (mode)
      PAR_ODD, PAR_EVEN, PAR_STICK0, PAR_STICK1: parity_enabled = 1'b1;
      default:                                   parity_enabled = 1'b0;
    endcase
  endfunction

  // Unused upper data bits are zero, so reducing all 9 bits is safe.
  function automatic logic expected_parity(input logic [2:0] mode, input logic [8:0] data);
    case (mode)
      PAR_ODD:    expected_parity = ~(^data);
      PAR_EVEN:   expected_parity = ^data;
      PAR_STICK0: expected_parity = 1'b0;
      PAR_STICK1: expected_parity = 1'b1;
      default:    expected_parity = 1'b0;
    endcase
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_mon_channel.sv
// One monitored line: synchronizer, frame FSM, holding register and frame counter.
// Frame counter exists only when UART_MON_COUNTERS_EN is defined.
module uart_mon_channel
  import uart_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [3:0]       data_bits_i,
  input  logic [2:0]       parity_i,
  input  logic             stop2_i,
  input  logic             line_i,
  input  logic             frame_ready_i,
  output logic             frame_valid_o,
  output logic [8:0]       frame_data_o,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  logic [1:0] sync_q;
  mon_state_e state_q;
  logic       busy_q;
  logic [3:0] tcnt_q;
  logic [3:0] bit_idx_q;
  logic [1:0] samp_q;
  logic [8:0] shift_q;
  logic       perr_q;
  logic       ferr_q;

  logic       hold_valid_q;
  logic [8:0] hold_data_q;
  logic       hold_perr_q;
  logic       hold_ferr_q;
  logic       ovr_q;

  logic       line_sync_s;
  logic       bit_s;
  logic [3:0] last_idx_s;
  logic       done_s;
  logic       fin_ferr_s;

  assign line_sync_s = sync_q[1];
  assign bit_s       = majority3(samp_q[0], samp_q[1], line_sync_s);
  assign last_idx_s  = eff_data_bits(data_bits_i) - 4'd1;
  assign done_s      = tick_i && (tcnt_q == SAMPLE_LATE) &&
                       (((state_q == ST_STOP1) && !stop2_i) || (state_q == ST_STOP2));
  assign fin_ferr_s  = ferr_q | ~bit_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

  // Bits are sampled at ticks 7/8/9 and the state advances at tick 15, so
  // each bit's samples always come from that bit's own window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      tcnt_q    <= 4'd0;
      bit_idx_q <= 4'd0;
      samp_q    <= 2'b11;
      shift_q   <= 9'd0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (tick_i) begin
      tcnt_q <= tcnt_q + 4'd1;
      if (tcnt_q == SAMPLE_EARLY) samp_q[0] <= line_sync_s;
      if (tcnt_q == SAMPLE_MID)   samp_q[1] <= line_sync_s;
      case (state_q)
        ST_IDLE: begin
          tcnt_q <= 4'd0;
          if (!line_sync_s) begin
            state_q   <= ST_START;
            busy_q    <= 1'b1;
            bit_idx_q <= 4'd0;
            shift_q   <= 9'd0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
          end
        end
        ST_START: begin
          if ((tcnt_q == SAMPLE_MID) && line_sync_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tcnt_q == TICK_LAST) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tcnt_q == SAMPLE_LATE) shift_q[bit_idx_q] <= bit_s;
          if (tcnt_q == TICK_LAST) begin
            if (bit_idx_q >= last_idx_s) begin
              bit_idx_q <= 4'd0;
              state_q   <= parity_enabled(parity_i) ? ST_PARITY : ST_STOP1;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tcnt_q == SAMPLE_LATE) perr_q <= (bit_s != expected_parity(parity_i, shift_q));
          if (tcnt_q == TICK_LAST) state_q <= ST_STOP1;
        end
        ST_STOP1: begin
          if (tcnt_q == SAMPLE_LATE) begin
            ferr_q <= fin_ferr_s;
            if (!stop2_i) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else if ((tcnt_q == TICK_LAST) && stop2_i) begin
            state_q <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (tcnt_q == SAMPLE_LATE) begin
            ferr_q  <= fin_ferr_s;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding register; a completion that finds it full is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 9'd0;
      hold_perr_q  <= 1'b0;
      hold_ferr_q  <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_s) begin
        if (!hold_valid_q || frame_ready_i) begin
          hold_valid_q <= 1'b1;
          hold_data_q  <= shift_q;
          hold_perr_q  <= perr_q;
          hold_ferr_q  <= fin_ferr_s;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (frame_ready_i) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_MON_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of every completed frame, dropped ones included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (done_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign frame_cnt_o = cnt_q;
`else
  assign frame_cnt_o = {CNT_W{1'b0}};
`endif

  assign frame_valid_o = hold_valid_q;
  assign frame_data_o  = hold_data_q;
  assign parity_err_o  = hold_perr_q;
  assign frame_err_o   = hold_ferr_q;
  assign overrun_o     = ovr_q;
  assign busy_o        = busy_q;

endmodule

// File: rtl/uart_frame_monitor.sv
// Multi-channel UART frame monitor: shared 16x prescaler plus one channel per line.
// Per-channel frame counters are enabled by defining UART_MON_COUNTERS_EN.
module uart_frame_monitor
  import uart_mon_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int PRESCALE_W = 16,
  parameter int CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PRESCALE_W-1:0]     prescale_i,
  input  logic [3:0]                data_bits_i,
  input  logic [2:0]                parity_i,
  input  logic                      stop2_i,
  input  logic [CHANNELS-1:0]       line_i,
  output logic [CHANNELS-1:0]       frame_valid_o,
  input  logic [CHANNELS-1:0]       frame_ready_i,
  output logic [CHANNELS*9-1:0]     frame_data_o,
  output logic [CHANNELS-1:0]       parity_err_o,
  output logic [CHANNELS-1:0]       frame_err_o,
  output logic [CHANNELS-1:0]       overrun_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS*CNT_W-1:0] frame_cnt_o
);

  logic [PRESCALE_W-1:0] pre_q;
  logic                  tick_s;

  // >= rather than == so a lowered prescale never strands the counter.
  assign tick_s = (pre_q >= prescale_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= {PRESCALE_W{1'b0}};
    end else if (tick_s) begin
      pre_q <= {PRESCALE_W{1'b0}};
    end else begin
      pre_q <= pre_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    uart_mon_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .tick_i        (tick_s),
      .data_bits_i   (data_bits_i),
      .parity_i      (parity_i),
      .stop2_i       (stop2_i),
      .line_i        (line_i[g]),
      .frame_ready_i (frame_ready_i[g]),
      .frame_valid_o (frame_valid_o[g]),
      .frame_data_o  (frame_data_o[g*9 +: 9]),
      .parity_err_o  (parity_err_o[g]),
      .frame_err_o   (frame_err_o[g]),
      .overrun_o     (overrun_o[g]),
      .busy_o        (busy_o[g]),
      .frame_cnt_o   (frame_cnt_o[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_uart_frame_monitor.sv
// Directed bench for uart_frame_monitor: table of single frames plus glitch,
// overrun and mid-frame reset sequences. Honours UART_MON_COUNTERS_EN.
module tb_uart_frame_monitor;
  localparam int CH = 2;
  localparam int PW = 16;
  localparam int CW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [PW-1:0]   prescale_i = 16'd0;
  logic [3:0]      data_bits_i = 4'd8;
  logic [2:0]      parity_i = 3'd0;
  logic            stop2_i = 1'b0;
  logic [CH-1:0]   line_i = 2'b11;
  logic [CH-1:0]   frame_valid_o;
  logic [CH-1:0]   frame_ready_i = 2'b00;
  logic [CH*9-1:0] frame_data_o;
  logic [CH-1:0]   parity_err_o;
  logic [CH-1:0]   frame_err_o;
  logic [CH-1:0]   overrun_o;
  logic [CH-1:0]   busy_o;
  logic [CH*CW-1:0] frame_cnt_o;

  uart_frame_monitor #(.CHANNELS(CH), .PRESCALE_W(PW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .prescale_i(prescale_i), .data_bits_i(data_bits_i),
    .parity_i(parity_i), .stop2_i(stop2_i), .line_i(line_i), .frame_valid_o(frame_valid_o),
    .frame_ready_i(frame_ready_i), .frame_data_o(frame_data_o), .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic [3:0] cfg_bits;
    int         ntx;
    logic [2:0] par;
    logic       stop2;
    logic       has_par;
    logic       pbit;
    logic       stop_low;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];
  int   n_total = 0;
  int   n_pass  = 0;
  int   ovr_cnt = 0;

`ifdef UART_MON_COUNTERS_EN
  localparam logic [15:0] CNT_AFTER_TWO = 16'd2;
  localparam logic [15:0] CNT_AFTER_ONE = 16'd1;
`else
  localparam logic [15:0] CNT_AFTER_TWO = 16'd0;
  localparam logic [15:0] CNT_AFTER_ONE = 16'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (overrun_o[0]) ovr_cnt++;
  endtask

  task automatic drive_bit(input int ch, input logic val);
    line_i[ch] = val;
    repeat (16) step();
  endtask

  task automatic send_frame(input int ch, input logic [8:0] data, input int ntx,
                            input logic has_par, input logic pbit, input int nstop,
                            input logic stop_low, input int gap);
    drive_bit(ch, 1'b0);
    for (int b = 0; b < ntx; b++) drive_bit(ch, data[b]);
    if (has_par) drive_bit(ch, pbit);
    drive_bit(ch, ~stop_low);
    if (nstop == 2) drive_bit(ch, 1'b1);
    line_i[ch] = 1'b1;
    repeat (gap) step();
  endtask

  task automatic wait_valid(input int ch, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (frame_valid_o[ch]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    logic ok;
    logic busy_seen;
    int   ch;

    //             ch  data    cfg   ntx par   s2    hasp  pbit  stlow exp     perr  ferr
    vecs[0] = '{0, 9'h0A5, 4'd8,  8, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h1F5, 4'd9,  9, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1F5, 1'b1, 1'b0};
    vecs[2] = '{0, 9'h03C, 4'd7,  7, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b1};
    vecs[3] = '{1, 9'h012, 4'd5,  5, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 9'h012, 1'b0, 1'b0};
    vecs[4] = '{0, 9'h081, 4'd15, 8, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 9'h081, 1'b1, 1'b0};
    vecs[5] = '{1, 9'h02A, 4'd6,  6, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h02A, 1'b0, 1'b0};
    vecs[6] = '{0, 9'h00F, 4'd4,  8, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 9'h00F, 1'b0, 1'b0};

    repeat (3) step();
    rst_i = 1'b0;
    check("reset valid", {30'd0, frame_valid_o}, 32'd0);
    check("reset busy", {30'd0, busy_o}, 32'd0);
    check("reset data", {14'd0, frame_data_o}, 32'd0);
    check("reset errs", {28'd0, parity_err_o, frame_err_o}, 32'd0);
    check("reset overrun", {30'd0, overrun_o}, 32'd0);
    check("reset count", frame_cnt_o, 32'd0);
    step();

    for (int i = 0; i < 7; i++) begin
      ch = vecs[i].ch;
      data_bits_i = vecs[i].cfg_bits;
      parity_i    = vecs[i].par;
      stop2_i     = vecs[i].stop2;
      send_frame(ch, vecs[i].data, vecs[i].ntx, vecs[i].has_par, vecs[i].pbit,
                 vecs[i].stop2 ? 2 : 1, vecs[i].stop_low, 24);
      wait_valid(ch, ok);
      check($sformatf("v%0d valid", i), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d data", i), {23'd0, frame_data_o[ch*9 +: 9]}, {23'd0, vecs[i].exp_data});
      check($sformatf("v%0d parity_err", i), {31'd0, parity_err_o[ch]}, {31'd0, vecs[i].exp_perr});
      check($sformatf("v%0d frame_err", i), {31'd0, frame_err_o[ch]}, {31'd0, vecs[i].exp_ferr});
      check($sformatf("v%0d other idle", i), {31'd0, frame_valid_o[1-ch]}, 32'd0);
      check($sformatf("v%0d busy", i), {30'd0, busy_o}, 32'd0);
      frame_ready_i[ch] = 1'b1;
      step();
      frame_ready_i[ch] = 1'b0;
      check($sformatf("v%0d valid clear", i), {31'd0, frame_valid_o[ch]}, 32'd0);
    end

    // 6-clock low glitch: false start, no frame
    data_bits_i = 4'd8; parity_i = 3'd0; stop2_i = 1'b0;
    busy_seen = 1'b0;
    line_i[0] = 1'b0;
    repeat (6) begin step(); busy_seen |= busy_o[0]; end
    line_i[0] = 1'b1;
    repeat (40) begin step(); busy_seen |= busy_o[0]; end
    check("glitch busy seen", {31'd0, busy_seen}, 32'd1);
    check("glitch busy idle", {31'd0, busy_o[0]}, 32'd0);
    check("glitch no valid", {31'd0, frame_valid_o[0]}, 32'd0);

    // back-to-back frames with ready low: second is dropped
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    ovr_cnt = 0;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b0, 0);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b0, 24);
    check("ovr valid held", {31'd0, frame_valid_o[0]}, 32'd1);
    check("ovr data held", {23'd0, frame_data_o[8:0]}, 32'h011);
    check("ovr pulse cycles", ovr_cnt, 32'd1);
    check("ovr count ch0", {16'd0, frame_cnt_o[15:0]}, {16'd0, CNT_AFTER_TWO});
    check("ovr count ch1", {16'd0, frame_cnt_o[31:16]}, 32'd0);

    // reset in the middle of a data bit on ch1 while ch0 holds a frame
    line_i[1] = 1'b0;
    repeat (16) step();
    line_i[1] = 1'b1;
    repeat (40) step();
    check("pre-reset busy", {31'd0, busy_o[1]}, 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid reset busy", {30'd0, busy_o}, 32'd0);
    check("mid reset valid", {30'd0, frame_valid_o}, 32'd0);
    check("mid reset count", frame_cnt_o, 32'd0);
    repeat (20) step();
    send_frame(1, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0, 24);
    wait_valid(1, ok);
    check("post reset valid", {31'd0, ok}, 32'd1);
    check("post reset data", {23'd0, frame_data_o[17:9]}, 32'h055);
    check("post reset errs", {30'd0, parity_err_o[1], frame_err_o[1]}, 32'd0);
    check("post reset count", {16'd0, frame_cnt_o[31:16]}, {16'd0, CNT_AFTER_ONE});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
